// File: rtl/throw_pkg.sv
// Shared types and constants for the projectile sequencer and its helpers.
package throw_pkg;

    localparam int SUBPIX_BITS = 4;
    localparam int VY_MIN      = -1024;

    typedef enum logic [1:0] {IDLE, ARM, FLIGHT, LANDED} throw_state_t;

endpackage

// File: rtl/frame_tick.sv
// Rising-edge detector on vertical blank: one tick per video frame.
module frame_tick (
    input  logic clk,
    input  logic rst,
    input  logic vblnk,
    output logic tick
);

    logic vblnk_q;

    always_ff @(posedge clk) begin
        if (rst) vblnk_q <= 1'b0;
        else     vblnk_q <= vblnk;
    end

    assign tick = vblnk & ~vblnk_q;

endmodule

// File: rtl/throw_ctl.sv
// Frame-synchronous ballistic sequencer: launch, per-frame gravity update,
// ground/edge detection, hold on the ground, then park off-screen.
module throw_ctl
    import throw_pkg::*;
#(
    parameter int GRAVITY     = 4,
    parameter int GROUND_Y    = 100,
    parameter int X_LIMIT     = 830,
    parameter int HOLD_FRAMES = 30,
    parameter int PARK_X      = 0,
    parameter int PARK_Y      = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        fire,
    input  logic [11:0] x0,
    input  logic [11:0] y0,
    input  logic [7:0]  vx_init,
    input  logic [7:0]  vy_init,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        busy,
    output logic        landed,
    output logic        lost,
    output logic [11:0] impact_x
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic signed [16:0] GROUND_SUB = 17'(GROUND_Y << SUBPIX_BITS);
    localparam logic [11:0] X_LIM  = 12'(X_LIMIT);
    localparam logic [11:0] PARK_XV = 12'(PARK_X);
    localparam logic [11:0] PARK_YV = 12'(PARK_Y);

    function automatic logic signed [10:0] sat_vy(input logic signed [11:0] v);
        if (v < VY_MIN) return 11'(VY_MIN);
        return v[10:0];
    endfunction

    throw_state_t state, state_nxt;
    logic [15:0] x_acc, y_acc, x_acc_nxt, y_acc_nxt;
    logic [7:0] vx, vx_nxt;
    logic signed [10:0] vy, vy_nxt;
    logic signed [11:0] vy_dec;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [11:0] impact_nxt, x_pos_nxt, y_pos_nxt;
    logic landed_nxt, lost_nxt;
    logic [15:0] x_n;
    logic signed [16:0] y_n;
    logic tick;

    frame_tick u_frame_tick (
        .clk   (clk),
        .rst   (rst),
        .vblnk (vblnk),
        .tick  (tick)
    );

    // Candidate next position; the horizontal step is always non-negative.
    assign x_n    = x_acc + 16'(vx);
    assign y_n    = $signed({1'b0, y_acc}) + 17'(vy);
    assign vy_dec = 12'(vy) - 12'(GRAVITY);

    always_comb begin
        state_nxt  = state;
        x_acc_nxt  = x_acc;
        y_acc_nxt  = y_acc;
        vx_nxt     = vx;
        vy_nxt     = vy;
        hold_nxt   = hold_cnt;
        impact_nxt = impact_x;
        landed_nxt = 1'b0;
        lost_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (fire) begin
                    x_acc_nxt = {x0, 4'b0000};
                    y_acc_nxt = {y0, 4'b0000};
                    vx_nxt    = vx_init;
                    vy_nxt    = {3'b000, vy_init};
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (tick) state_nxt = FLIGHT;
            end
            FLIGHT: begin
                if (tick) begin
                    vy_nxt = sat_vy(vy_dec);
                    // Ground check first so a simultaneous edge exit still lands.
                    if (y_n < GROUND_SUB) begin
                        y_acc_nxt  = GROUND_SUB[15:0];
                        x_acc_nxt  = x_n;
                        impact_nxt = x_n[15:4];
                        landed_nxt = 1'b1;
                        hold_nxt   = '0;
                        state_nxt  = LANDED;
                    end else if (x_n[15:4] >= X_LIM) begin
                        lost_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        x_acc_nxt = x_n;
                        y_acc_nxt = y_n[15:0];
                    end
                end
            end
            LANDED: begin
                if (tick) begin
                    if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
                    else                       hold_nxt  = HOLD_W'(hold_cnt + 1'b1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == IDLE) begin
            x_pos_nxt = PARK_XV;
            y_pos_nxt = PARK_YV;
        end else begin
            x_pos_nxt = x_acc_nxt[15:4];
            y_pos_nxt = y_acc_nxt[15:4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            x_acc    <= '0;
            y_acc    <= '0;
            vx       <= '0;
            vy       <= '0;
            hold_cnt <= '0;
            impact_x <= '0;
            x_pos    <= PARK_XV;
            y_pos    <= PARK_YV;
            busy     <= 1'b0;
            landed   <= 1'b0;
            lost     <= 1'b0;
        end else begin
            state    <= state_nxt;
            x_acc    <= x_acc_nxt;
            y_acc    <= y_acc_nxt;
            vx       <= vx_nxt;
            vy       <= vy_nxt;
            hold_cnt <= hold_nxt;
            impact_x <= impact_nxt;
            x_pos    <= x_pos_nxt;
            y_pos    <= y_pos_nxt;
            busy     <= (state_nxt != IDLE);
            landed   <= landed_nxt;
            lost     <= lost_nxt;
        end
    end

endmodule

// File: tb/tb_throw_ctl.sv
// Bench for throw_ctl: vector table, directed corner sequences, random run vs. reference model.
module tb_throw_ctl;

    logic        clk = 1'b0;
    logic        rst, vblnk, fire;
    logic [11:0] x0, y0;
    logic [7:0]  vx_init, vy_init;
    logic [11:0] x_pos, y_pos, impact_x;
    logic        busy, landed, lost;

    throw_ctl dut (
        .clk      (clk),
        .rst      (rst),
        .vblnk    (vblnk),
        .fire     (fire),
        .x0       (x0),
        .y0       (y0),
        .vx_init  (vx_init),
        .vy_init  (vy_init),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .busy     (busy),
        .landed   (landed),
        .lost     (lost),
        .impact_x (impact_x)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int n_land_seen = 0, n_launch = 0;
    logic busy_prev = 1'b0;

    // Reference model: projectile described by launch values and frames flown.
    localparam int M_PARKED = 0, M_WAIT_FRAME = 1, M_AIR = 2, M_REST = 3;
    int m_mode = M_PARKED, m_prev = 0, m_k = 0, m_hold = 0;
    int m_x0 = 0, m_y0 = 0, m_vx = 0, m_vy = 0, m_xs = 0, m_ys = 0;
    int e_x = 0, e_y = 0, e_busy = 0, e_landed = 0, e_lost = 0, e_impact = 0;

    task automatic model_edge();
        int t, xn, yn;
        e_landed = 0;
        e_lost   = 0;
        if (rst) begin
            m_mode = M_PARKED; m_prev = 0; m_xs = 0; m_ys = 0; e_impact = 0;
        end else begin
            t = (vblnk && !m_prev) ? 1 : 0;
            m_prev = vblnk;
            case (m_mode)
                M_PARKED: if (fire) begin
                    m_x0 = x0; m_y0 = y0; m_vx = vx_init; m_vy = vy_init;
                    m_xs = m_x0 * 16; m_ys = m_y0 * 16; m_k = 0;
                    m_mode = M_WAIT_FRAME;
                end
                M_WAIT_FRAME: if (t != 0) m_mode = M_AIR;
                M_AIR: if (t != 0) begin
                    m_k++;
                    // Closed form of constant-acceleration motion after k frames.
                    xn = m_x0 * 16 + m_k * m_vx;
                    yn = m_y0 * 16 + m_k * m_vy - 2 * m_k * (m_k - 1);
                    if (yn < 100 * 16) begin
                        m_xs = xn; m_ys = 100 * 16; e_impact = xn / 16;
                        e_landed = 1; m_hold = 0; m_mode = M_REST;
                    end else if (xn / 16 >= 830) begin
                        e_lost = 1; m_mode = M_PARKED;
                    end else begin
                        m_xs = xn; m_ys = yn;
                    end
                end
                M_REST: if (t != 0) begin
                    m_hold++;
                    if (m_hold == 30) m_mode = M_PARKED;
                end
                default: m_mode = M_PARKED;
            endcase
        end
        e_busy = (m_mode != M_PARKED) ? 1 : 0;
        e_x = (e_busy != 0) ? m_xs / 16 : 0;
        e_y = (e_busy != 0) ? m_ys / 16 : 0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("model.x_pos", int'(x_pos), e_x);
        chk("model.y_pos", int'(y_pos), e_y);
        chk("model.busy", int'(busy), e_busy);
        chk("model.landed", int'(landed), e_landed);
        chk("model.lost", int'(lost), e_lost);
        chk("model.impact_x", int'(impact_x), e_impact);
        if (landed) n_land_seen++;
        if (busy && !busy_prev) n_launch++;
        busy_prev = busy;
    endtask

    task automatic frame();
        vblnk = 1'b1; cycle(); cycle();
        vblnk = 1'b0; cycle(); cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; vblnk = 1'b0; fire = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
    endtask

    task automatic launch(input int ax, input int ay, input int avx, input int avy);
        x0 = 12'(ax); y0 = 12'(ay); vx_init = 8'(avx); vy_init = 8'(avy);
        fire = 1'b1; cycle(); fire = 1'b0;
    endtask

    typedef struct {
        int x0, y0, vx, vy, frames, ex, ey, ebusy, eimp;
    } vec_t;

    vec_t vt[10];

    initial begin
        rst = 1'b1; vblnk = 1'b0; fire = 1'b0;
        x0 = '0; y0 = '0; vx_init = '0; vy_init = '0;

        vt[0] = '{100, 100,  32,  64,  1, 100, 100, 1,   0};
        vt[1] = '{100, 100,  32,  64, 17, 132, 134, 1,   0};
        vt[2] = '{100, 100,  32,  64, 18, 134, 134, 1,   0};
        vt[3] = '{100, 100,  32,  64, 34, 166, 100, 1,   0};
        vt[4] = '{100, 100,  32,  64, 35, 168, 100, 1, 168};
        vt[5] = '{100, 100,  32,  64, 65,   0,   0, 0, 168};
        vt[6] = '{ 50, 100,  16,   0,  2,  51, 100, 1,   0};
        vt[7] = '{ 50, 100,  16,   0,  3,  52, 100, 1,  52};
        vt[8] = '{800, 200, 255, 255,  2, 815, 215, 1,   0};
        vt[9] = '{800, 200, 255, 255,  3,   0,   0, 0,   0};

        do_reset();
        chk("reset.x_pos", int'(x_pos), 0);
        chk("reset.y_pos", int'(y_pos), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.impact_x", int'(impact_x), 0);

        foreach (vt[i]) begin
            do_reset();
            launch(vt[i].x0, vt[i].y0, vt[i].vx, vt[i].vy);
            for (int f = 0; f < vt[i].frames; f++) frame();
            chk($sformatf("vec%0d.x_pos", i), int'(x_pos), vt[i].ex);
            chk($sformatf("vec%0d.y_pos", i), int'(y_pos), vt[i].ey);
            chk($sformatf("vec%0d.busy", i), int'(busy), vt[i].ebusy);
            chk($sformatf("vec%0d.impact_x", i), int'(impact_x), vt[i].eimp);
        end

        // fire held high: one flight, relaunch only once back in IDLE
        do_reset();
        n_land_seen = 0; n_launch = 0;
        x0 = 12'd100; y0 = 12'd100; vx_init = 8'd32; vy_init = 8'd64;
        fire = 1'b1;
        cycle();
        for (int f = 0; f < 64; f++) frame();
        chk("hold_fire.launches_in_arc", n_launch, 1);
        chk("hold_fire.landings", n_land_seen, 1);
        frame();
        chk("hold_fire.relaunch_busy", int'(busy), 1);
        chk("hold_fire.relaunch_x", int'(x_pos), 100);
        chk("hold_fire.launches_total", n_launch, 2);
        fire = 1'b0;

        // reset in mid-flight, then relaunch from new coordinates
        do_reset();
        launch(100, 100, 32, 64);
        for (int f = 0; f < 11; f++) frame();
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("midrst.x_pos", int'(x_pos), 0);
        chk("midrst.y_pos", int'(y_pos), 0);
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.landed", int'(landed), 0);
        chk("midrst.lost", int'(lost), 0);
        launch(300, 150, 10, 10);
        frame();
        chk("midrst.relaunch_x", int'(x_pos), 300);
        chk("midrst.relaunch_y", int'(y_pos), 150);

        // long vblank: a single advance per rising edge
        do_reset();
        launch(100, 100, 32, 64);
        frame();
        vblnk = 1'b1;
        for (int c = 0; c < 20; c++) cycle();
        vblnk = 1'b0; cycle(); cycle();
        chk("longvb.x_pos", int'(x_pos), 102);
        chk("longvb.y_pos", int'(y_pos), 104);

        // randomized run against the model
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 1) == 1) vblnk = ~vblnk;
            fire    = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 799) == 0);
            x0      = 12'($urandom_range(0, 900));
            y0      = 12'($urandom_range(50, 800));
            vx_init = 8'($urandom_range(0, 255));
            vy_init = 8'($urandom_range(0, 255));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/throw_ctl.md
Name: throw_ctl

Overview:
- Frame-synchronous ballistic sequencer for one projectile.
- On a fire request it latches the launch position and velocity, then advances the position once per video frame with constant gravity. It detects ground impact or left-side exit, holds the result, and then parks the projectile off-screen.
- x_pos/y_pos drive draw_projectile directly, in its convention: column = HOR_PIXELS - x_pos, row = VER_PIXELS - y_pos.
- It sits between the game/turn logic (fire, velocities) and the drawing chain.

Parameters:
- GRAVITY, 4: subpixels/frame² subtracted from vertical velocity each frame tick (1 px = 16 subpixels).
- GROUND_Y, 100: y_pos value at which the projectile is on the ground (pixels).
- X_LIMIT, 830: x_pos at or beyond which the projectile is lost off-screen (pixels).
- HOLD_FRAMES, 30: frame ticks spent in LANDED before returning to IDLE.
- PARK_X, 0: x_pos presented when the projectile is not in flight; off-screen.
- PARK_Y, 0: y_pos presented when the projectile is not in flight; off-screen.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- vblnk  in  1  vertical blank from VGA timing; its rising edge is the frame tick
- fire  in  1  launch request, single-cycle or level
- x0  in  12  launch x_pos (pixels)
- y0  in  12  launch y_pos (pixels)
- vx_init  in  8  horizontal speed, unsigned, subpixels/frame (+x direction)
- vy_init  in  8  vertical speed, unsigned, subpixels/frame upward
- x_pos  out  12  current x (pixels)
- y_pos  out  12  current y (pixels)
- busy  out  1  high in any state other than IDLE
- landed  out  1  one-cycle pulse on ground impact
- lost  out  1  one-cycle pulse on exit past X_LIMIT
- impact_x  out  12  x_pos at impact, held until the next launch

Behaviour:
- Reset state, also forced by rst mid-flight with no pulses emitted: state IDLE; x_pos=PARK_X, y_pos=PARK_Y; busy=0, landed=0, lost=0, impact_x=0; accumulators 0.
- Frame tick: vblnk registered once; tick = vblnk & ~vblnk_q.
- Internal state: 16-bit unsigned accumulators x_acc/y_acc in 12.4 fixed point, and a signed 11-bit vy.
- Outputs are x_pos = x_acc[15:4] and y_pos = y_acc[15:4] while in FLIGHT or LANDED; PARK values in IDLE. All outputs are registered.
- States:
  - IDLE: when fire=1, latch x_acc = {x0,4'b0}, y_acc = {y0,4'b0}, vx = vx_init, vy = +vy_init, then go to ARM. fire in any other state is ignored.
  - ARM: on the next tick go to FLIGHT with no position change. This makes the first visible frame the launch point.
  - FLIGHT: on each tick compute x_n = x_acc + vx and y_n = y_acc + vy using 17-bit signed arithmetic; then set vy = vy - GRAVITY, saturating at -1024. Checks are made in this order:
    1. If y_n < GROUND_Y*16: set y_acc = GROUND_Y*16 and x_acc = x_n; load impact_x = x_n[15:4]; pulse landed; go to LANDED.
    2. Else if x_n[15:4] >= X_LIMIT: pulse lost; impact_x is unchanged; go to IDLE.
    3. Otherwise: x_acc = x_n, y_acc = y_n.
    - If both conditions hold on one tick, landed wins.
    - y_n equal to GROUND_Y*16 is not an impact.
  - LANDED: the position is frozen. A frame counter counts HOLD_FRAMES ticks, then the block goes to IDLE and outputs return to park.
- Latency: position outputs change on the clk edge after the tick cycle. landed/lost pulse in the same cycle as the final position update.
- Ticks are the only advance event; fire is never queued.

Decomposition:
- Add to vga_pkg or a new throw_pkg:
  - typedef enum {IDLE, ARM, FLIGHT, LANDED} throw_state_t
  - SUBPIX_BITS = 4
- One natural sub-module, frame_tick: vblnk rising-edge detector, reusable by other frame-rate logic.

Test Plan:
- Nominal arc, x0=100, y0=100, vx=32, vy=64, GROUND_Y=100, GRAVITY=4, fire then ticks:
  - After the ARM tick, pos stays (100,100).
  - Peak y_pos=134 after the 16th and 17th FLIGHT ticks.
  - After tick 33, y_pos=100 with no landing.
  - landed pulses on tick 34 with x_pos=168, y_pos=100, impact_x=168.
  - After 30 more ticks, busy=0 and pos=(0,0).
- Lost, x0=800, vy=255, vx=255: lost pulses on the 2nd FLIGHT tick (x_pos would be 831); next cycle busy=0; impact_x unchanged.
- fire held high throughout the nominal arc: exactly one launch. A second launch happens only after returning to IDLE.
- vy_init=0, y0=GROUND_Y: first FLIGHT tick gives y_n=1600 (no impact); second tick gives 1596 → landed.
- rst asserted mid-FLIGHT (tick 10): next cycle state IDLE, pos=(0,0), no pulses; a new fire relaunches from the fresh x0/y0.
- vblnk held high for many cycles: exactly one tick per rising edge; position advances only once.
